// File: rtl/xor_and_checker.sv
// Self-test engine for the gate y = (a ^ b) & c.
// Steps {a,b,c} through 000..111, holds each vector for SETTLE_CYCLES cycles,
// samples y for one further cycle and compares it with a built-in golden model.
// It reports pass/fail, a saturating mismatch count and the first failing vector.
module xor_and_checker #(
  parameter int SETTLE_CYCLES = 4,
  parameter int ERR_W         = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  output logic             a,
  output logic             b,
  output logic             c,
  input  logic             y,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [ERR_W-1:0] err_count,
  output logic [2:0]       fail_vec,
  output logic             fail_valid
);

  localparam int CNT_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SETTLE_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DRIVE  = 2'd1,
    SAMPLE = 2'd2,
    DONE   = 2'd3
  } state_t;

  state_t             state, state_nxt;
  logic [2:0]         v, v_nxt;
  logic [CNT_W-1:0]   cnt, cnt_nxt;
  logic [ERR_W-1:0]   err_nxt;
  logic [2:0]         fail_vec_nxt;
  logic               fail_valid_nxt;
  logic               expected_y;

  // The vector register is the stimulus itself, so {a,b,c} is registered and
  // naturally rests at 111 in DONE and at 000 after reset.
  assign {a, b, c} = v;

  // Golden model: the gate's output for the vector currently on the pins.
  assign expected_y = (v[2] ^ v[1]) & v[0];

  // Next-state, next-vector and result-register logic.
  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned,
    // which would otherwise infer a latch.
    state_nxt      = state;
    v_nxt          = v;
    cnt_nxt        = cnt;
    err_nxt        = err_count;
    fail_vec_nxt   = fail_vec;
    fail_valid_nxt = fail_valid;

    case (state)
      IDLE, DONE: begin
        // A start from DONE is a restart and clears everything from IDLE too.
        if (start) begin
          state_nxt      = DRIVE;
          v_nxt          = 3'd0;
          cnt_nxt        = '0;
          err_nxt        = '0;
          fail_vec_nxt   = 3'd0;
          fail_valid_nxt = 1'b0;
        end
      end

      DRIVE: begin
        if (cnt == CNT_LAST) begin
          state_nxt = SAMPLE;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end

      SAMPLE: begin
        if (y != expected_y) begin
          if (err_count != '1) begin
            err_nxt = err_count + 1'b1;
          end
          if (!fail_valid) begin
            fail_vec_nxt   = v;
            fail_valid_nxt = 1'b1;
          end
        end
        if (v == 3'd7) begin
          state_nxt = DONE;
        end else begin
          v_nxt     = v + 3'd1;
          cnt_nxt   = '0;
          state_nxt = DRIVE;
        end
      end

      default: state_nxt = IDLE;
    endcase
  end

  // State and datapath registers; status flags are registered from next-state
  // values so no output has a combinational path from y or start.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of statement order.
    if (rst) begin
      state      <= IDLE;
      v          <= 3'd0;
      cnt        <= '0;
      err_count  <= '0;
      fail_vec   <= 3'd0;
      fail_valid <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      pass       <= 1'b0;
    end else begin
      state      <= state_nxt;
      v          <= v_nxt;
      cnt        <= cnt_nxt;
      err_count  <= err_nxt;
      fail_vec   <= fail_vec_nxt;
      fail_valid <= fail_valid_nxt;
      busy       <= (state_nxt == DRIVE) || (state_nxt == SAMPLE);
      done       <= (state_nxt == DONE);
      pass       <= (state_nxt == DONE) && (err_nxt == '0);
    end
  end

endmodule

// File: tb/tb_xor_and_checker.sv
// Bench for xor_and_checker: three instances (default parameters, ERR_W=2,
// SETTLE_CYCLES=1) each driving a modelled gate whose output is the golden
// truth table XORed with a per-vector fault mask.
module tb_xor_and_checker;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic       start      [3];
  logic       a_o        [3];
  logic       b_o        [3];
  logic       c_o        [3];
  logic       y_i        [3];
  logic       busy_o     [3];
  logic       done_o     [3];
  logic       pass_o     [3];
  logic       fvalid_o   [3];
  logic [2:0] fvec_o     [3];
  logic [7:0] mask       [3];
  logic [3:0] err_def;
  logic [1:0] err_e2;
  logic [3:0] err_s1;

  int vectors     = 0;
  int miscompares = 0;

  // Truth table of the gate: high only for {a,b,c} = 011 and 101.
  function automatic logic golden(input logic [2:0] vec);
    return (vec == 3'b011) || (vec == 3'b101);
  endfunction

  // Gate under test: golden output, inverted where the fault mask has a bit set.
  for (genvar g = 0; g < 3; g++) begin : g_gate
    assign y_i[g] = golden({a_o[g], b_o[g], c_o[g]}) ^ mask[g][{a_o[g], b_o[g], c_o[g]}];
  end

  xor_and_checker u_def (
    .clk(clk), .rst(rst), .start(start[0]),
    .a(a_o[0]), .b(b_o[0]), .c(c_o[0]), .y(y_i[0]),
    .busy(busy_o[0]), .done(done_o[0]), .pass(pass_o[0]),
    .err_count(err_def), .fail_vec(fvec_o[0]), .fail_valid(fvalid_o[0])
  );

  xor_and_checker #(.ERR_W(2)) u_e2 (
    .clk(clk), .rst(rst), .start(start[1]),
    .a(a_o[1]), .b(b_o[1]), .c(c_o[1]), .y(y_i[1]),
    .busy(busy_o[1]), .done(done_o[1]), .pass(pass_o[1]),
    .err_count(err_e2), .fail_vec(fvec_o[1]), .fail_valid(fvalid_o[1])
  );

  xor_and_checker #(.SETTLE_CYCLES(1)) u_s1 (
    .clk(clk), .rst(rst), .start(start[2]),
    .a(a_o[2]), .b(b_o[2]), .c(c_o[2]), .y(y_i[2]),
    .busy(busy_o[2]), .done(done_o[2]), .pass(pass_o[2]),
    .err_count(err_s1), .fail_vec(fvec_o[2]), .fail_valid(fvalid_o[2])
  );

  function automatic int settle_of(input int i);
    return (i == 2) ? 1 : 4;
  endfunction

  function automatic int errw_of(input int i);
    return (i == 1) ? 2 : 4;
  endfunction

  function automatic logic [7:0] err_of(input int i);
    case (i)
      0:       return {4'd0, err_def};
      1:       return {6'd0, err_e2};
      default: return {4'd0, err_s1};
    endcase
  endfunction

  function automatic logic [7:0] abc_of(input int i);
    return {5'd0, a_o[i], b_o[i], c_o[i]};
  endfunction

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_reset_values(input int i, input string where);
    check($sformatf("%s[%0d].abc", where, i),        abc_of(i),        8'd0);
    check($sformatf("%s[%0d].busy", where, i),       busy_o[i],        8'd0);
    check($sformatf("%s[%0d].done", where, i),       done_o[i],        8'd0);
    check($sformatf("%s[%0d].pass", where, i),       pass_o[i],        8'd0);
    check($sformatf("%s[%0d].err", where, i),        err_of(i),        8'd0);
    check($sformatf("%s[%0d].fail_vec", where, i),   {5'd0, fvec_o[i]}, 8'd0);
    check($sformatf("%s[%0d].fail_valid", where, i), fvalid_o[i],      8'd0);
  endtask

  // One complete run on instance i with fault mask m; optionally re-pulses
  // start while vector 4 is on the pins. Expected results come from counting
  // and locating the set bits of the mask.
  task automatic run(input int i, input logic [7:0] m, input bit repulse);
    int s   = settle_of(i);
    int n   = 8 * (s + 1);
    int sat = (1 << errw_of(i)) - 1;
    int pc  = $countones(m);
    int first = 0;
    for (int k = 7; k >= 0; k--) if (m[k]) first = k;
    mask[i] = m;
    @(negedge clk) start[i] = 1'b1;
    @(negedge clk) start[i] = 1'b0;
    check($sformatf("run[%0d].clr_err", i),    err_of(i),   8'd0);
    check($sformatf("run[%0d].clr_fvalid", i), fvalid_o[i], 8'd0);
    for (int t = 1; t <= n; t++) begin
      start[i] = repulse && (t == 4 * (s + 1) + 1);
      check($sformatf("run[%0d].t%0d.busy", i, t), busy_o[i], 8'd1);
      check($sformatf("run[%0d].t%0d.done", i, t), done_o[i], 8'd0);
      check($sformatf("run[%0d].t%0d.abc", i, t),  abc_of(i), 8'((t - 1) / (s + 1)));
      @(negedge clk);
    end
    start[i] = 1'b0;
    check($sformatf("run[%0d].done", i),       done_o[i],         8'd1);
    check($sformatf("run[%0d].busy_end", i),   busy_o[i],         8'd0);
    check($sformatf("run[%0d].abc_end", i),    abc_of(i),         8'd7);
    check($sformatf("run[%0d].pass", i),       pass_o[i],         8'(m == 8'd0));
    check($sformatf("run[%0d].err", i),        err_of(i),         8'((pc > sat) ? sat : pc));
    check($sformatf("run[%0d].fail_valid", i), fvalid_o[i],       8'(m != 8'd0));
    check($sformatf("run[%0d].fail_vec", i),   {5'd0, fvec_o[i]}, 8'(first));
  endtask

  // Start a failing run on the default instance and assert reset during the
  // SAMPLE cycle of vector 5; everything must return to reset values and stay idle.
  task automatic abort_run();
    mask[0] = 8'h28;
    @(negedge clk) start[0] = 1'b1;
    @(negedge clk) start[0] = 1'b0;
    repeat (6 * (settle_of(0) + 1) - 1) @(negedge clk);
    check("abort.abc_before", abc_of(0), 8'd5);
    check("abort.err_before", err_of(0), 8'd1);
    rst = 1'b1;
    @(negedge clk) rst = 1'b0;
    check_reset_values(0, "abort");
    for (int t = 0; t < 10; t++) begin
      @(negedge clk);
      check($sformatf("idle.t%0d.busy", t), busy_o[0], 8'd0);
      check($sformatf("idle.t%0d.abc", t),  abc_of(0), 8'd0);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    for (int i = 0; i < 3; i++) begin
      start[i] = 1'b0;
      mask[i]  = 8'd0;
    end
    rst = 1'b1;
    repeat (3) @(negedge clk);
    for (int i = 0; i < 3; i++) check_reset_values(i, "reset");
    rst = 1'b0;

    run(0, 8'h00, 1'b0);   // correct gate
    run(0, 8'h28, 1'b0);   // y stuck at 0
    run(0, 8'hD7, 1'b0);   // y stuck at 1
    run(1, 8'hFF, 1'b0);   // inverted gate, 2-bit counter saturates
    run(0, 8'h00, 1'b1);   // start re-pulsed while busy
    run(0, 8'h28, 1'b0);   // failing run ...
    run(0, 8'h00, 1'b0);   // ... then restart from DONE must clear results
    run(2, 8'h00, 1'b0);   // single-cycle settle
    run(2, 8'h28, 1'b0);
    abort_run();

    for (int r = 0; r < 8; r++) begin
      run(int'($urandom_range(0, 2)), 8'($urandom), 1'($urandom_range(0, 1)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/xor_and_checker.md
# xor_and_checker

On-board self-test engine for the 3-input XOR-followed-by-AND gate (`y = (a ^ b) & c`). It drives all eight input combinations into the gate in ascending order, waits for the output to settle, and samples the gate's `y` against a built-in golden model. It reports pass/fail, a saturating error count and the first failing vector. It sits between the Basys 3 button/LED glue and the gate instance, and replaces the simulation stimulus with synthesizable hardware.

## Interface
Parameters:
- `SETTLE_CYCLES`, default 4: cycles each vector is held before sampling; legal range ≥ 1.
- `ERR_W`, default 4: width of the error counter.

Ports:
- `clk`  in  1: system clock.
- `rst`  in  1: synchronous, active-high reset.
- `start`  in  1: request a test run; level-sampled on `clk`.
- `a`, `b`, `c`  out  1 each: registered stimulus to the gate; `{a,b,c}` equals vector index, `a` is the MSB.
- `y`  in  1: gate output under test.
- `busy`  out  1: run in progress.
- `done`  out  1: run complete; level output.
- `pass`  out  1: high only when `done` is high and `err_count` is 0.
- `err_count`  out  ERR_W: mismatches in the last run; saturates at all-ones.
- `fail_vec`  out  3: `{a,b,c}` of the first mismatch.
- `fail_valid`  out  1: `fail_vec` holds a captured vector.

## Operation
States are IDLE, DRIVE, SAMPLE and DONE. Vector index `v` is 3 bits. Settle counter `cnt` counts 0 to SETTLE_CYCLES-1.
- IDLE → DRIVE when `start` is high.
  - On the transition: `v`=0, `cnt`=0, `err_count`=0, `fail_valid`=0, `fail_vec`=0.
- DONE → DRIVE when `start` is high. This is a restart and clears the same registers as IDLE → DRIVE.
- DRIVE: `{a,b,c}` = `v`; `cnt` increments each cycle. When `cnt` = SETTLE_CYCLES-1, the next state is SAMPLE.
- SAMPLE, one cycle:
  - Compare `y` against `(a^b)&c` of the current `v`.
  - On mismatch: increment `err_count` unless it is all-ones. If `fail_valid` is 0, load `fail_vec`=`v` and set `fail_valid`.
  - If `v`=7, go to DONE. Otherwise `v`++, `cnt`=0, and go to DRIVE.
- DONE: `{a,b,c}` holds 3'b111. `err_count`, `fail_vec` and `fail_valid` hold their values until the next start or reset.
- `busy` is high in DRIVE and SAMPLE. `done` is high only in DONE.
- `start` is ignored while `busy` is high. Holding `start` high continuously makes the block re-run back-to-back; DONE is visible for one cycle between runs.
- Golden truth table, with vector written as `{a,b,c}`: expected `y`=1 only at 3'b011 and 3'b101.

## Timing
- Reset values for all outputs: `a`=`b`=`c`=0, `busy`=0, `done`=0, `pass`=0, `err_count`=0, `fail_vec`=0, `fail_valid`=0. State is IDLE.
- `rst` mid-run aborts immediately to IDLE with the reset values above; no partial results are retained.
- `start` is sampled at edge k:
  - `busy` rises and `{a,b,c}`=000 after edge k.
  - Vector `v` is driven for SETTLE_CYCLES+1 cycles (SETTLE_CYCLES in DRIVE plus 1 in SAMPLE).
  - `y` is sampled at edge k+(v+1)(SETTLE_CYCLES+1).
  - `done` rises and `busy` falls after edge k+8(SETTLE_CYCLES+1). With default parameters this is 40 cycles.
- `err_count` and `fail_*` update at the SAMPLE edge and are visible the following cycle.
- All outputs are registered; there is no combinational path from `y` or `start` to any output.

## Test plan
- Correct DUT connected, default parameters, `start` pulsed at edge k → `busy` is high for 40 cycles. `{a,b,c}` steps 000..111, each value held 5 cycles. After edge k+40: `done`=1, `pass`=1, `err_count`=0, `fail_valid`=0.
- `y` tied to 0 → `done` with `pass`=0, `err_count`=2, `fail_vec`=3'b011, `fail_valid`=1.
- `y` tied to 1 → `err_count`=6, `fail_vec`=3'b000. Repeat with `ERR_W`=2 and `y` = inverted golden output → 8 mismatches; `err_count` saturates at 3 and `fail_vec`=000.
- `start` re-pulsed while busy at vector 4 → ignored; `done` still arrives at edge k+40. `start` pulsed in DONE after a failing run → counters clear, a new 40-cycle run starts, and `pass`=1 with a correct DUT.
- `rst` asserted during the SAMPLE of vector 5 → after the edge, all outputs are at reset values and the state is IDLE. No activity occurs until the next `start`.
- `SETTLE_CYCLES`=1 → each vector is held 2 cycles, `done` arrives 16 cycles after `start`, and results match scenario 1.
